// File: rtl/switch_allocator_pkg.sv
// Shared NoC constants and types for the switch allocator.
// SA_STARVATION_MON_EN enables per-VC age counters and starve flags.
package switch_allocator_pkg;

  localparam int NOC_PORT_NUM    = 5;
  localparam int NOC_BUFFER_SIZE = 8;
  localparam int VC_NUM          = 2;
  localparam int VC_SIZE         = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int PORT_SIZE       = $clog2(NOC_PORT_NUM);
  localparam int SA_AGE_W        = 8;

  typedef logic [PORT_SIZE-1:0] port_t;
  typedef logic [VC_SIZE-1:0]   vc_t;
  typedef logic [SA_AGE_W-1:0]  age_t;

  function automatic vc_t vc_next(vc_t v);
    return (int'(v) == VC_NUM - 1) ? '0 : v + vc_t'(1);
  endfunction

  function automatic port_t port_next(port_t p, int n);
    return (int'(p) == n - 1) ? '0 : p + port_t'(1);
  endfunction

endpackage

// File: rtl/switch_allocator_if.sv
// Request/grant bundle between input ports, allocator and crossbar.
// master: input-port side; slave: the allocator.
interface switch_allocator_if;
  import switch_allocator_pkg::*;

  logic  [NOC_PORT_NUM-1:0][VC_NUM-1:0] switch_request_i;
  port_t [NOC_PORT_NUM-1:0][VC_NUM-1:0] out_port_i;
  vc_t   [NOC_PORT_NUM-1:0][VC_NUM-1:0] downstream_vc_i;
  logic  [NOC_PORT_NUM-1:0]             credit_valid_i;
  vc_t   [NOC_PORT_NUM-1:0]             credit_vc_i;
  logic  [NOC_PORT_NUM-1:0]             valid_sel_o;
  vc_t   [NOC_PORT_NUM-1:0]             vc_sel_o;
  logic  [NOC_PORT_NUM-1:0]             xb_valid_o;
  port_t [NOC_PORT_NUM-1:0]             xb_sel_o;
  logic  [NOC_PORT_NUM-1:0]             credit_error_o;
  logic  [NOC_PORT_NUM-1:0][VC_NUM-1:0] starve_o;

  modport master (
    output switch_request_i,
    output out_port_i,
    output downstream_vc_i,
    output credit_valid_i,
    output credit_vc_i,
    input  valid_sel_o,
    input  vc_sel_o,
    input  xb_valid_o,
    input  xb_sel_o,
    input  credit_error_o,
    input  starve_o
  );

  modport slave (
    input  switch_request_i,
    input  out_port_i,
    input  downstream_vc_i,
    input  credit_valid_i,
    input  credit_vc_i,
    output valid_sel_o,
    output vc_sel_o,
    output xb_valid_o,
    output xb_sel_o,
    output credit_error_o,
    output starve_o
  );

endinterface

// File: rtl/switch_allocator_arb.sv
// Round-robin arbiter: first request at or after ptr wins.
// Combinational; one-hot grant plus any-grant flag.
module round_robin_arbiter #(
  parameter int N = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          valid
);

  logic found;

  // scan N positions starting at ptr, grant the first requester
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < N; j++) begin
        if (!found && req[j] && j == (int'(ptr) + k) % N) begin
          gnt[j] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/switch_allocator.sv
// Separable input-first switch allocator with downstream credits.
// Optional SA_STARVATION_MON_EN: per-VC age counters drive starve_o.
module switch_allocator
  import switch_allocator_pkg::*;
#(
  parameter int PORT_NUM    = NOC_PORT_NUM,
  parameter int BUFFER_SIZE = NOC_BUFFER_SIZE
) (
  input logic               clk,
  input logic               rst,
  switch_allocator_if.slave bus
);

  localparam int CW = $clog2(BUFFER_SIZE + 1);
  typedef logic [CW-1:0] cred_t;
  localparam cred_t FULL = cred_t'(BUFFER_SIZE);

  cred_t credit_q [PORT_NUM][VC_NUM];
  vc_t   in_ptr_q [PORT_NUM];
  port_t out_ptr_q [PORT_NUM];

  logic  [PORT_NUM-1:0]             valid_sel_q;
  vc_t   [PORT_NUM-1:0]             vc_sel_q;
  logic  [PORT_NUM-1:0]             xb_valid_q;
  port_t [PORT_NUM-1:0]             xb_sel_q;
  logic  [PORT_NUM-1:0]             err_q;

  logic  [PORT_NUM-1:0][VC_NUM-1:0] elig;
  logic  [PORT_NUM-1:0][VC_NUM-1:0] starving;
  logic  [PORT_NUM-1:0][VC_NUM-1:0] s1_req;
  logic  [VC_NUM-1:0]               s1_gnt [PORT_NUM];
  logic                             s1_vld [PORT_NUM];
  vc_t                              cand_vc [PORT_NUM];
  port_t                            cand_port [PORT_NUM];
  vc_t                              cand_dvc [PORT_NUM];

  logic  [PORT_NUM-1:0][PORT_NUM-1:0] s2_req;
  logic  [PORT_NUM-1:0]             s2_gnt [PORT_NUM];
  logic                             s2_vld [PORT_NUM];
  port_t                            win_in [PORT_NUM];
  logic  [PORT_NUM-1:0]             in_won;

  logic  [VC_NUM-1:0]               dec [PORT_NUM];
  logic  [VC_NUM-1:0]               inc [PORT_NUM];

  // a VC is eligible when it requests and its downstream VC has credit
  always_comb begin
    elig = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      for (int v = 0; v < VC_NUM; v++) begin
        for (int o = 0; o < PORT_NUM; o++) begin
          if (bus.switch_request_i[i][v] &&
              bus.out_port_i[i][v] == port_t'(o) &&
              credit_q[o][bus.downstream_vc_i[i][v]] != '0)
            elig[i][v] = 1'b1;
        end
      end
    end
  end

  // eligible starving VCs pre-empt the normal round-robin order
  always_comb begin
    for (int i = 0; i < PORT_NUM; i++) begin
      if (|(elig[i] & starving[i]))
        s1_req[i] = elig[i] & starving[i];
      else
        s1_req[i] = elig[i];
    end
  end

  for (genvar g = 0; g < PORT_NUM; g++) begin : g_s1
    round_robin_arbiter #(.N(VC_NUM)) u_arb (
      .req   (s1_req[g]),
      .ptr   (in_ptr_q[g]),
      .gnt   (s1_gnt[g]),
      .valid (s1_vld[g])
    );
  end

  // encode each input's stage-1 winner and look up its route
  always_comb begin
    for (int i = 0; i < PORT_NUM; i++) begin
      cand_vc[i] = '0;
      for (int v = 0; v < VC_NUM; v++) begin
        if (s1_gnt[i][v])
          cand_vc[i] = vc_t'(v);
      end
      cand_port[i] = bus.out_port_i[i][cand_vc[i]];
      cand_dvc[i]  = bus.downstream_vc_i[i][cand_vc[i]];
    end
  end

  // each output sees the inputs whose candidate targets it
  always_comb begin
    s2_req = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      for (int i = 0; i < PORT_NUM; i++) begin
        s2_req[o][i] = s1_vld[i] &&
                       cand_port[i] == port_t'(o);
      end
    end
  end

  for (genvar g = 0; g < PORT_NUM; g++) begin : g_s2
    round_robin_arbiter #(.N(PORT_NUM)) u_arb (
      .req   (s2_req[g]),
      .ptr   (out_ptr_q[g]),
      .gnt   (s2_gnt[g]),
      .valid (s2_vld[g])
    );
  end

  // stage-2 winners per output and full-grant flags per input
  always_comb begin
    in_won = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      win_in[o] = '0;
      for (int i = 0; i < PORT_NUM; i++) begin
        if (s2_gnt[o][i]) begin
          win_in[o] = port_t'(i);
          in_won[i] = 1'b1;
        end
      end
    end
  end

  // per-counter consume (grant) and return (credit) strobes
  always_comb begin
    for (int o = 0; o < PORT_NUM; o++) begin
      dec[o] = '0;
      inc[o] = '0;
      for (int c = 0; c < VC_NUM; c++) begin
        dec[o][c] = s2_vld[o] &&
                    cand_dvc[win_in[o]] == vc_t'(c);
        inc[o][c] = bus.credit_valid_i[o] &&
                    bus.credit_vc_i[o] == vc_t'(c);
      end
    end
  end

  // credit counters; return to a full counter saturates and flags
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_q <= '0;
      for (int o = 0; o < PORT_NUM; o++)
        for (int c = 0; c < VC_NUM; c++)
          credit_q[o][c] <= FULL;
    end else begin
      for (int o = 0; o < PORT_NUM; o++) begin
        for (int c = 0; c < VC_NUM; c++) begin
          if (inc[o][c] && !dec[o][c]) begin
            if (credit_q[o][c] == FULL)
              err_q[o] <= 1'b1;
            else
              credit_q[o][c] <= credit_q[o][c] + cred_t'(1);
          end else if (dec[o][c] && !inc[o][c]) begin
            credit_q[o][c] <= credit_q[o][c] - cred_t'(1);
          end
        end
      end
    end
  end

  // register grants; pointers move only on a full grant
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_sel_q <= '0;
      vc_sel_q    <= '0;
      xb_valid_q  <= '0;
      xb_sel_q    <= '0;
      for (int i = 0; i < PORT_NUM; i++) begin
        in_ptr_q[i]  <= '0;
        out_ptr_q[i] <= '0;
      end
    end else begin
      valid_sel_q <= in_won;
      for (int i = 0; i < PORT_NUM; i++) begin
        vc_sel_q[i] <= in_won[i] ? cand_vc[i] : '0;
        if (in_won[i])
          in_ptr_q[i] <= vc_next(cand_vc[i]);
      end
      for (int o = 0; o < PORT_NUM; o++) begin
        xb_valid_q[o] <= s2_vld[o];
        xb_sel_q[o]   <= s2_vld[o] ? win_in[o] : '0;
        if (s2_vld[o])
          out_ptr_q[o] <= port_next(win_in[o], PORT_NUM);
      end
    end
  end

`ifdef SA_STARVATION_MON_EN
  age_t age_q [PORT_NUM][VC_NUM];

  // age waiting requests; clear on grant or withdrawal, saturate
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < PORT_NUM; i++)
        for (int v = 0; v < VC_NUM; v++)
          age_q[i][v] <= '0;
    end else begin
      for (int i = 0; i < PORT_NUM; i++) begin
        for (int v = 0; v < VC_NUM; v++) begin
          if (!bus.switch_request_i[i][v] ||
              (in_won[i] && cand_vc[i] == vc_t'(v)))
            age_q[i][v] <= '0;
          else if (age_q[i][v] != '1)
            age_q[i][v] <= age_q[i][v] + age_t'(1);
        end
      end
    end
  end

  // a saturated age counter marks the VC as starving
  always_comb begin
    for (int i = 0; i < PORT_NUM; i++)
      for (int v = 0; v < VC_NUM; v++)
        starving[i][v] = (age_q[i][v] == '1);
  end
`else
  assign starving = '0;
`endif

  assign bus.valid_sel_o    = valid_sel_q;
  assign bus.vc_sel_o       = vc_sel_q;
  assign bus.xb_valid_o     = xb_valid_q;
  assign bus.xb_sel_o       = xb_sel_q;
  assign bus.credit_error_o = err_q;
  assign bus.starve_o       = starving;

endmodule

// File: doc/switch_allocator.md
Name: switch_allocator

Overview:
- Separable input-first switch allocator with per-downstream-VC credit tracking.
- Sits between the input ports' switch-request outputs and the crossbar.
- Each cycle it picks at most one VC per input port and at most one input per output port.
- It only grants a flit when the target downstream VC holds at least one credit.
- Grants drive the input ports' VC-select/valid strobes and the crossbar select lines.

Parameters:
- PORT_NUM, 5, number of input and output ports.
- BUFFER_SIZE, 8, downstream buffer depth per VC; initial and maximum credit count.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- switch_request_i  in  [PORT_NUM][VC_NUM]  per input VC: head-of-line flit awaiting switch traversal.
- out_port_i  in  [PORT_NUM][VC_NUM] port_t  routed output port per input VC.
- downstream_vc_i  in  [PORT_NUM][VC_NUM][VC_SIZE]  allocated downstream VC per input VC.
- credit_valid_i  in  [PORT_NUM]  credit returned on output port p.
- credit_vc_i  in  [PORT_NUM][VC_SIZE]  VC of the returned credit.
- valid_sel_o  out  [PORT_NUM]  input port p is granted this cycle.
- vc_sel_o  out  [PORT_NUM][VC_SIZE]  granted VC at input p.
- xb_valid_o  out  [PORT_NUM]  output port o is driven this cycle.
- xb_sel_o  out  [PORT_NUM][PORT_SIZE]  input index routed to output o.
- credit_error_o  out  [PORT_NUM]  sticky; credit returned to an already-full counter.
- starve_o  out  [PORT_NUM][VC_NUM]  starvation flag (optional feature).

Behaviour:
- Reset (rst==0 at posedge):
  - All outputs 0.
  - Credit counters = BUFFER_SIZE.
  - All round-robin pointers = 0.
  - Age counters = 0.
- Eligibility: input VC (i,v) is eligible iff switch_request_i[i][v] && credit[out_port_i[i][v]][downstream_vc_i[i][v]] > 0.
- Stage 1, combinational: per input i, round-robin over eligible VCs starting at in_ptr[i] gives candidate (i,v1).
- Stage 2, combinational: per output o, round-robin over inputs whose candidate targets o, starting at out_ptr[o], gives winner input i.
- Outputs are registered, one-cycle latency:
  - Request sampled at edge t produces valid_sel_o/vc_sel_o/xb_* during cycle t+1.
  - Both stage grants are consistent: valid_sel_o[i]=1 implies exactly one o with xb_valid_o[o]=1 and xb_sel_o[o]=i.
- Pointer update happens only on a full grant (iSLIP rule):
  - in_ptr[i] <= v1+1 mod VC_NUM.
  - out_ptr[o] <= i+1 mod PORT_NUM.
  - Stage-1 winners that lose stage 2 leave their pointers unchanged.
- Credits:
  - Counter width $clog2(BUFFER_SIZE+1).
  - Decrement at the grant edge; this prevents back-to-back over-grant of the last credit.
  - Increment on credit_valid_i.
  - Grant and credit return on the same counter in the same cycle: net unchanged.
  - Credit return at BUFFER_SIZE: count stays saturated, credit_error_o[o] set, held until reset.
- Zero-credit downstream VC is never granted, even if it is the only requester.
- No requests: all valid outputs 0, pointers unchanged.
- The requester owns request deassertion after grant; this block does not track packets.
- Reset mid-operation: in-flight grant outputs are dropped the next cycle; credits are restored to full.

Optional Feature:
- Macro SA_STARVATION_MON_EN.
- Defined:
  - Each (i,v) has an 8-bit age counter.
  - Counter increments while switch_request_i is high and not granted; it clears on grant or on deassertion.
  - At 255 it saturates and starve_o[i][v]=1 (registered).
  - A starving VC overrides in_ptr in stage 1 on the next cycle; this is for monitoring and assertion.
- Undefined: starve_o tied to 0; no counters are synthesized.

Decomposition:
- noc_params holds port_t, VC_NUM, VC_SIZE, PORT_SIZE, PORT_NUM-compatible constants. Add SA_AGE_W=8 there.
- One natural sub-module: round_robin_arbiter #(N) with request vector, pointer in, one-hot grant out, and grant-valid.
- The arbiter is instantiated PORT_NUM times per stage.

Test Plan:
- Reset then single request (i=0,v=1,out=2,dvc=0) -> next cycle valid_sel_o[0]=1, vc_sel_o[0]=1, xb_valid_o[2]=1, xb_sel_o[2]=0, credit[2][0]=7.
- Inputs 0,1,3 request output 4 continuously, each with 8+ credits returned -> xb_sel_o[4] cycles 0,1,3,0,... one grant per cycle.
- Input 2 requests v0 and v1, both to different outputs -> vc_sel_o[2] alternates 0,1,0,1.
- Hold a request to (out=1,dvc=0) with no credit returns -> exactly 8 grants, then valid outputs stay 0. One credit_valid_i[1] with vc 0 -> exactly one further grant.
- Credit return and grant on the same counter in the same cycle -> count unchanged. Credit return at count 8 -> count stays 8, credit_error_o[1]=1 sticky.
- With SA_STARVATION_MON_EN, block a VC 255 cycles via zero credit -> starve_o asserts. Return a credit -> grant on the next cycle, starve_o clears. Without the macro, starve_o stays 0.
